button_event: RTL and testbench
===============================

// Module: button_event
// PURPOSE
// Consumer side of the debouncer interface. Takes the debounced level (pressed) and the
// one-cycle press strobe (press_pulse) and classifies each press as short, long or
// auto-repeat. Output strobes drive the time-setting logic of the digital clock.
// One instance per button sits between the debouncer and the clock-set controller.
// PARAMETERS
// HOLD_TICKS    100  ticks of continuous press before long_pulse (>=1, < 2**CNT_W)
// REPEAT_TICKS  20   ticks between repeat_pulse strobes after long press (>=1, < 2**CNT_W)
// CNT_W         8    width of the internal tick counter
// PORTS
// clk           in   1  system clock
// rst           in   1  synchronous reset, active-high
// tick          in   1  one-cycle timebase strobe (e.g. 100 Hz); all timing counts ticks
// pressed       in   1  debounced level, high while the button is held
// press_pulse   in   1  one-cycle strobe on the debounced press edge
// short_pulse   out  1  one cycle: released before HOLD_TICKS ticks
// long_pulse    out  1  one cycle: hold reached HOLD_TICKS ticks
// repeat_pulse  out  1  one cycle: every REPEAT_TICKS ticks after long_pulse while held
// step_pulse    out  1  short_pulse | long_pulse | repeat_pulse (increment strobe)
// held          out  1  level: high while in HOLD state
// BEHAVIOUR
// - Reset: state IDLE, cnt=0, all outputs 0. Takes precedence over all inputs.
// - All outputs registered. A pulse is high for exactly one clk, in the cycle after the
//   edge at which its condition was sampled. step_pulse is aligned with its source pulse.
// - States: IDLE, PRESS, HOLD. Counter cnt (CNT_W bits) is cleared on every state entry.
// - IDLE: press_pulse & pressed -> PRESS. pressed without press_pulse (button already
//   held out of reset) -> stay IDLE, no events. tick is ignored.
// - PRESS: !pressed -> short_pulse, go IDLE. Else on tick: cnt==HOLD_TICKS-1 ->
//   long_pulse, go HOLD; otherwise cnt+1.
// - HOLD: held=1. !pressed -> go IDLE, no pulse. Else on tick: cnt==REPEAT_TICKS-1 ->
//   repeat_pulse, cnt=0; otherwise cnt+1.
// - Release wins: if !pressed and a terminal-count tick occur in the same cycle, PRESS
//   emits short_pulse only, and HOLD emits nothing.
// - press_pulse in PRESS or HOLD is ignored. It does not restart the count.
// - cnt never wraps, because it is cleared at its terminal count.
// - held deasserts in the cycle after the release or reset edge.
// - Reset mid-press or mid-hold: go IDLE, emit no pulse, and emit no short_pulse later.
// TESTING
// 1 rst=1 3 cycles with pressed=1, tick toggling -> all outputs 0; after rst=0 with
//   pressed still 1 and no press_pulse -> no pulse for 20 ticks.
// 2 HOLD=4: press_pulse+pressed, 2 ticks, release -> exactly one short_pulse+step_pulse
//   1 cycle after release; long_pulse never high.
// 3 HOLD=4, REPEAT=2: hold for 10 ticks -> long_pulse after tick 4, repeat_pulse after
//   ticks 6, 8, 10 (3 total). held high from the cycle after tick 4. Release -> no short.
// 4 HOLD=4: release in the same cycle as tick 4 -> one short_pulse, no long_pulse,
//   held stays 0.
// 5 REPEAT=2 in HOLD: assert rst mid-count -> held=0 and all pulses 0 next cycle; later
//   ticks with pressed=0 -> nothing.
// 6 press_pulse pulsed again during PRESS after 2 ticks -> long_pulse still after tick 4
//   of the original press.

Source files
------------

// File: rtl/button_event_if.sv
// Purpose : signal bundle between the button debouncer and the button_event
//           classifier. The debouncer side (master) drives the timebase tick,
//           the debounced level and the press strobe; the classifier side
//           (slave) returns the event strobes and the held level.
// Signals :
//   tick         master->slave  one-cycle timebase strobe
//   pressed      master->slave  debounced level, high while held
//   press_pulse  master->slave  one-cycle strobe on the debounced press edge
//   short_pulse  slave->master  one cycle: released before the hold time
//   long_pulse   slave->master  one cycle: hold time reached
//   repeat_pulse slave->master  one cycle: auto-repeat while held
//   step_pulse   slave->master  OR of the three event strobes
//   held         slave->master  level: high while in the hold phase
// Handshake semantics: there is no valid/ready pair here. Every strobe is a
// single-cycle qualifier that is consumed in the cycle it is high; the
// receiver can never stall the sender, so nothing is held waiting.
interface button_event_if;
  logic tick;
  logic pressed;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic step_pulse;
  logic held;

  modport master (
    output tick, pressed, press_pulse,
    input  short_pulse, long_pulse, repeat_pulse, step_pulse, held
  );

  modport slave (
    input  tick, pressed, press_pulse,
    output short_pulse, long_pulse, repeat_pulse, step_pulse, held
  );
endinterface

// File: rtl/button_event.sv
// Purpose : classifies each debounced button press as short, long or
//           auto-repeat and emits one-cycle strobes for the clock-set logic.
// Ports   :
//   clk      in   system clock
//   rst      in   synchronous reset, active-high, wins over all inputs
//   bus      if   button_event_if.slave (tick/pressed/press_pulse in,
//                 short/long/repeat/step pulses and held level out)
//   state_o  out  current FSM state (0 IDLE, 1 PRESS, 2 HOLD) for observation
// Parameters:
//   HOLD_TICKS    ticks of continuous press before long_pulse
//   REPEAT_TICKS  ticks between repeat_pulse strobes while held
//   CNT_W         tick counter width
module button_event #(
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  button_event_if.slave      bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             short_q;
  logic             long_q;
  logic             repeat_q;
  logic             step_q;
  logic             held_q;

  // Single registered FSM: every output is a flop, so each strobe appears
  // exactly one cycle after the edge at which its condition was sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      step_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      step_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          held_q <= 1'b0;
          // A level that is already high without an edge strobe (e.g. held
          // through reset) must not start a press.
          if (bus.press_pulse && bus.pressed) begin
            state_q <= ST_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_PRESS: begin
          // Release is tested first so it wins over a terminal-count tick.
          if (!bus.pressed) begin
            short_q <= 1'b1;
            step_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (bus.tick) begin
            if (cnt_q == HOLD_LAST) begin
              long_q  <= 1'b1;
              step_q  <= 1'b1;
              held_q  <= 1'b1;
              state_q <= ST_HOLD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.pressed) begin
            held_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (bus.tick) begin
            if (cnt_q == REPEAT_LAST) begin
              repeat_q <= 1'b1;
              step_q   <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          held_q  <= 1'b0;
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.short_pulse  = short_q;
  assign bus.long_pulse   = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.step_pulse   = step_q;
  assign bus.held         = held_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with HOLD_TICKS=4, REPEAT_TICKS=2. Each table row is
// one clock cycle of inputs plus the outputs required in the following cycle,
// packed as {short, long, repeat, step, held}.
module tb_button_event;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  button_event_if bus ();

  button_event #(
    .HOLD_TICKS   (4),
    .REPEAT_TICKS (2),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tick;
    logic       pressed;
    logic       pp;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_SHORT = 5'b10010;
  localparam logic [4:0] E_LONG  = 5'b01011;
  localparam logic [4:0] E_REP   = 5'b00111;
  localparam logic [4:0] E_HELD  = 5'b00001;

  vec_t       vecs[$];
  string      cur_tag;
  logic [4:0] exp_q[$];
  int         checks;
  int         failures;

  function automatic void v(input logic r, input logic t, input logic p,
                            input logic pp, input logic [4:0] e);
    vec_t x;
    x.rst = r; x.tick = t; x.pressed = p; x.pp = pp; x.exp = e; x.tag = cur_tag;
    vecs.push_back(x);
  endfunction

  // press followed by n ticks that stay below the hold time
  function automatic void press_ticks(input int n);
    v(0, 0, 1, 1, E_NONE);
    for (int i = 0; i < n; i++) v(0, 1, 1, 0, E_NONE);
  endfunction

  // driver
  task automatic drive(input vec_t x);
    @(negedge clk);
    rst             = x.rst;
    bus.tick        = x.tick;
    bus.pressed     = x.pressed;
    bus.press_pulse = x.pp;
    exp_q.push_back(x.exp);
  endtask

  // scoreboard: pop and compare once the DUT has registered the cycle
  task automatic check(input string tag, input int idx);
    logic [4:0] got;
    logic [4:0] e;
    @(posedge clk);
    #1;
    got = {bus.short_pulse, bus.long_pulse, bus.repeat_pulse,
           bus.step_pulse, bus.held};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s row %0d: no expected entry queued", tag, idx);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL %s row %0d: got {s,l,r,st,h}=%b expected %b",
                 tag, idx, got, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.pressed = 1'b0;
    bus.press_pulse = 1'b0;

    // 1: reset wins with pressed and ticks; held-out-of-reset level ignored
    cur_tag = "reset";
    v(1, 1, 1, 1, E_NONE);
    v(1, 0, 1, 0, E_NONE);
    v(1, 1, 1, 0, E_NONE);
    cur_tag = "held_from_reset";
    for (int i = 0; i < 20; i++) begin
      v(0, 1, 1, 0, E_NONE);
      v(0, 0, 1, 0, E_NONE);
    end
    v(0, 0, 0, 0, E_NONE);

    // 2: short press
    cur_tag = "short";
    press_ticks(2);
    v(0, 0, 1, 0, E_NONE);
    v(0, 0, 0, 0, E_SHORT);
    v(0, 0, 0, 0, E_NONE);

    // 3: long press with auto-repeat, release gives no short
    cur_tag = "long_repeat";
    press_ticks(3);
    v(0, 1, 1, 0, E_LONG);           // tick 4
    v(0, 0, 1, 0, E_HELD);
    for (int t = 5; t <= 10; t++) begin
      v(0, 1, 1, 0, (t % 2 == 0) ? E_REP : E_HELD);
      v(0, 0, 1, 0, E_HELD);
    end
    v(0, 0, 0, 0, E_NONE);
    v(0, 1, 0, 0, E_NONE);

    // 4: release coincides with tick 4 -> short only
    cur_tag = "release_wins";
    press_ticks(3);
    v(0, 1, 0, 0, E_SHORT);
    v(0, 0, 0, 0, E_NONE);
    v(0, 1, 0, 0, E_NONE);

    // 6: second press_pulse mid-press does not restart the count
    cur_tag = "repress";
    press_ticks(2);
    v(0, 0, 1, 1, E_NONE);
    v(0, 1, 1, 0, E_NONE);           // tick 3
    v(0, 1, 1, 1, E_LONG);           // tick 4 with stray press_pulse
    v(0, 0, 1, 1, E_HELD);           // press_pulse ignored in HOLD
    v(0, 1, 1, 0, E_HELD);
    v(0, 0, 0, 0, E_NONE);

    // 5: reset mid-hold
    cur_tag = "reset_hold";
    press_ticks(3);
    v(0, 1, 1, 0, E_LONG);
    v(0, 1, 1, 0, E_HELD);           // mid repeat count
    v(1, 1, 1, 0, E_NONE);           // would be a repeat tick
    for (int i = 0; i < 3; i++) begin
      v(0, 1, 0, 0, E_NONE);
      v(0, 0, 0, 0, E_NONE);
    end

    // reset mid-press: no short afterwards
    cur_tag = "reset_press";
    press_ticks(1);
    v(1, 0, 1, 0, E_NONE);
    v(0, 0, 1, 0, E_NONE);
    v(0, 0, 0, 0, E_NONE);
    v(0, 1, 0, 0, E_NONE);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check(vecs[i].tag, i);
    end

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
